// File: rtl/clk_div_detect.sv
// -----------------------------------------------------------------------------
// clk_div_detect
//
// Measures the rising-edge spacing of an asynchronous divided-clock pulse
// train and works out which power-of-two divide setting produced it. After
// LOCK_COUNT consecutive equal power-of-two periods the detector locks and
// reports the divide exponent on div_out. It drops lock when it sees a
// different period or when no edge arrives in time.
//
// Parameters
//   CLK_DIV_SIZE : width of div_out; periods 2^1 .. 2^(2^CLK_DIV_SIZE-1)
//   LOCK_COUNT   : consecutive equal valid periods needed to lock (2..15)
//
// Ports
//   clk     in   single clock domain
//   rst     in   asynchronous, active-high reset
//   sig_in  in   divided-clock pulse train, asynchronous to clk
//   clr     in   synchronous restart, active-high
//   div_out out  detected divide exponent d (period = 2^d), 0 when unlocked
//   period  out  last measured period in clk cycles (PW = 2^CLK_DIV_SIZE+1)
//   valid   out  one-cycle pulse when period updates
//   locked  out  high while locked
//   err     out  one-cycle pulse on an invalid period, lost lock or timeout
// -----------------------------------------------------------------------------
module clk_div_detect #(
   parameter int CLK_DIV_SIZE = 3,
   parameter int LOCK_COUNT   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sig_in,
   input  logic                          clr,
   output logic [CLK_DIV_SIZE-1:0]       div_out,
   output logic [2**CLK_DIV_SIZE:0]      period,
   output logic                          valid,
   output logic                          locked,
   output logic                          err
);

   localparam int PW    = 2**CLK_DIV_SIZE + 1;
   localparam int MAX_K = 2**CLK_DIV_SIZE - 1;
   // The counter value at which a missing edge counts as a timeout.
   localparam logic [PW-1:0] TIMEOUT = PW'(1) << (PW - 1);

   typedef enum logic [1:0] {
      HUNT,
      TRACK,
      LOCKED
   } state_e;

   // Synchronizer and edge detector
   logic       sync1_q, sync2_q, sync3_q;
   logic [2:0] fill_q;
   logic       edge_det;

   // FSM and datapath state
   state_e                  state_q, state_d;
   logic [PW-1:0]           cnt_q, cnt_d;
   logic [3:0]              match_q, match_d;
   logic [CLK_DIV_SIZE-1:0] cand_q, cand_d;
   logic [CLK_DIV_SIZE-1:0] div_q, div_d;
   logic [PW-1:0]           period_q, period_d;
   logic                    valid_q, valid_d;
   logic                    locked_q, locked_d;
   logic                    err_q, err_d;

   // Measurement decode
   logic [PW-1:0]           cnt_inc;
   logic                    meas_ok;
   logic [CLK_DIV_SIZE-1:0] meas_k;
   logic [3:0]              track_match;
   logic                    lock_hit;
   logic                    timeout;

   // clr deliberately leaves the synchronizer alone so a restart cannot
   // create or swallow an edge on the asynchronous input.
   // fill_q marks when sync3_q holds a real post-reset sample; until then a
   // sig_in that was already high at reset release cannot look like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         fill_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values and the pipeline shifts by one stage.
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         fill_q  <= {fill_q[1:0], 1'b1};
      end
   end

   assign edge_det = fill_q[2] & sync2_q & ~sync3_q;

   // Period decode: a period is usable only when it is 2^k for an exponent
   // that div_out can represent.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + PW'(1);
      meas_ok = 1'b0;
      meas_k  = '0;
      for (int k = 1; k <= MAX_K; k++) begin
         if (cnt_inc == (PW'(1) << k)) begin
            meas_ok = 1'b1;
            meas_k  = CLK_DIV_SIZE'(k);
         end
      end
      track_match = (meas_k == cand_q) ? match_q + 4'd1 : 4'd1;
      lock_hit    = meas_ok && (track_match == 4'(LOCK_COUNT));
      timeout     = (state_q != HUNT) && (cnt_q == TIMEOUT);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   // FSM next-state logic. Priority: clr, then edge, then timeout.
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = HUNT;
      end else if (edge_det) begin
         case (state_q)
            HUNT:    state_d = TRACK;
            TRACK:   if (lock_hit) state_d = LOCKED;
            LOCKED:  if (!(meas_ok && meas_k == div_q)) state_d = TRACK;
            default: state_d = HUNT;
         endcase
      end else if (timeout) begin
         state_d = HUNT;
      end
   end

   // FSM output / datapath logic
   always_comb begin
      cnt_d    = cnt_inc;
      match_d  = match_q;
      cand_d   = cand_q;
      div_d    = div_q;
      period_d = period_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      err_d    = 1'b0;
      if (clr) begin
         cnt_d    = '0;
         match_d  = '0;
         cand_d   = '0;
         div_d    = '0;
         period_d = '0;
         locked_d = 1'b0;
      end else if (edge_det) begin
         cnt_d = '0;
         // The first edge seen in HUNT only starts the measurement.
         if (state_q != HUNT) begin
            period_d = cnt_inc;
            valid_d  = 1'b1;
         end
         case (state_q)
            TRACK: begin
               if (meas_ok) begin
                  cand_d  = meas_k;
                  match_d = track_match;
                  if (lock_hit) begin
                     div_d    = meas_k;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d = '0;
                  err_d   = 1'b1;
               end
            end
            LOCKED: begin
               if (!(meas_ok && meas_k == div_q)) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  div_d    = '0;
                  if (meas_ok) begin
                     cand_d  = meas_k;
                     match_d = 4'd1;
                  end else begin
                     match_d = '0;
                  end
               end
            end
            default: ;
         endcase
      end else if (timeout) begin
         // The counter keeps running past TIMEOUT and HUNT ignores it, so
         // this fires once per lost signal.
         err_d    = 1'b1;
         locked_d = 1'b0;
         div_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         match_q  <= '0;
         cand_q   <= '0;
         div_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         match_q  <= match_d;
         cand_q   <= cand_d;
         div_q    <= div_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign div_out = div_q;
   assign period  = period_q;
   assign valid   = valid_q;
   assign locked  = locked_q;
   assign err     = err_q;

endmodule

// File: tb/tb_clk_div_detect.sv
// -----------------------------------------------------------------------------
// tb_clk_div_detect
//
// Directed bench for clk_div_detect (CLK_DIV_SIZE=3, LOCK_COUNT=4). A
// behavioural model works from edge timing, powers of two and a run length,
// and a compare process checks every output each cycle. Literal expectations
// after each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_clk_div_detect;

   localparam int N    = 3;
   localparam int PW   = 2**N + 1;
   localparam int LOCK = 4;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          sig_in = 1'b0;
   logic          clr    = 1'b0;
   logic [N-1:0]  div_out;
   logic [PW-1:0] period;
   logic          valid;
   logic          locked;
   logic          err;

   clk_div_detect #(
      .CLK_DIV_SIZE (N),
      .LOCK_COUNT   (LOCK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sig_in  (sig_in),
      .clr     (clr),
      .div_out (div_out),
      .period  (period),
      .valid   (valid),
      .locked  (locked),
      .err     (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   typedef enum int {M_HUNT, M_TRACK, M_LOCKED} mode_e;

   mode_e         m_mode    = M_HUNT;
   int            m_elapsed = 0;   // clk edges since the last accepted edge
   int            m_nsamp   = 0;   // sig_in samples taken since reset
   int            m_cand    = 0;
   int            m_run     = 0;   // consecutive equal valid periods
   bit            m_s1, m_s2, m_s3; // last three sig_in samples, s1 newest
   logic [N-1:0]  e_div     = '0;
   logic [PW-1:0] e_period  = '0;
   logic          e_valid   = 1'b0;
   logic          e_locked  = 1'b0;
   logic          e_err     = 1'b0;

   // Exponent k when p = 2^k with 1 <= k <= 2^N-1, otherwise -1.
   function automatic int pow2_exp(input int p);
      for (int k = 1; k <= 2**N - 1; k++)
         if (p == (1 << k)) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = M_HUNT; m_elapsed = 0; m_nsamp = 0; m_cand = 0; m_run = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
      e_div = '0; e_period = '0; e_valid = 0; e_locked = 0; e_err = 0;
   endtask

   task automatic model_step();
      bit rise;
      int p, k;
      // A rising edge becomes visible two samples late, and only once the
      // sample before it was taken after reset.
      rise = (m_nsamp >= 3) && m_s2 && !m_s3;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = sig_in;
      if (m_nsamp < 3) m_nsamp++;
      if (m_elapsed < 100000) m_elapsed++;
      e_valid = 0;
      e_err   = 0;
      if (clr) begin
         m_mode = M_HUNT; m_elapsed = 0; m_cand = 0; m_run = 0;
         e_div = '0; e_period = '0; e_locked = 0;
      end else if (rise) begin
         if (m_mode == M_HUNT) begin
            m_mode = M_TRACK;
         end else begin
            p = (m_elapsed > 2**PW - 1) ? 2**PW - 1 : m_elapsed;
            k = pow2_exp(p);
            e_period = PW'(p);
            e_valid  = 1;
            if (m_mode == M_TRACK) begin
               if (k < 0) begin
                  m_run = 0;
                  e_err = 1;
               end else begin
                  m_run  = (k == m_cand) ? m_run + 1 : 1;
                  m_cand = k;
                  if (m_run == LOCK) begin
                     m_mode   = M_LOCKED;
                     e_locked = 1;
                     e_div    = N'(k);
                  end
               end
            end else if (k != int'(e_div)) begin
               e_err    = 1;
               e_locked = 0;
               e_div    = '0;
               m_mode   = M_TRACK;
               if (k >= 0) begin m_cand = k; m_run = 1; end
               else        m_run = 0;
            end
         end
         m_elapsed = 0;
      end else if (m_mode != M_HUNT && m_elapsed == 2**(2**N) + 1) begin
         e_err    = 1;
         e_locked = 0;
         e_div    = '0;
         m_mode   = M_HUNT;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else     model_step();
      end
   end

   // ---------------------------------------------------------------------------
   // Compare process and event monitor (1 ns after each rising edge)
   // ---------------------------------------------------------------------------
   bit            cmp_en      = 0;
   int            n_valid     = 0;
   int            n_err       = 0;
   int            lock_idx    = 0;
   logic          prev_locked = 0;
   logic [PW-1:0] last_period = '0;
   logic          err_locked  = 0;
   logic [N-1:0]  err_div     = '0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cmp_en) begin
            check("cyc_valid",  32'(valid),   32'(e_valid));
            check("cyc_err",    32'(err),     32'(e_err));
            check("cyc_locked", 32'(locked),  32'(e_locked));
            check("cyc_div",    32'(div_out), 32'(e_div));
            check("cyc_period", 32'(period),  32'(e_period));
         end
         if (valid === 1'b1) begin
            n_valid++;
            last_period = period;
            if (locked === 1'b1 && prev_locked !== 1'b1) lock_idx = n_valid;
         end
         if (err === 1'b1) begin
            n_err++;
            err_locked = locked;
            err_div    = div_out;
         end
         prev_locked = locked;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling edge)
   // ---------------------------------------------------------------------------
   task automatic wave(input int per, input int hi, input int n);
      for (int j = 0; j < n; j++)
         for (int i = 0; i < per; i++) begin
            @(negedge clk);
            sig_in = (i < hi);
         end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sig_in = 1'b0;
      end
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic zero_counts();
      n_valid  = 0;
      n_err    = 0;
      lock_idx = 0;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int lat;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_div",    32'(div_out), 0);
      check("rst_period", 32'(period),  0);
      check("rst_valid",  32'(valid),   0);
      check("rst_locked", 32'(locked),  0);
      check("rst_err",    32'(err),     0);
      rst    = 1'b0;
      cmp_en = 1;

      // Period 8: lock with div 3 on the 4th valid after the HUNT edge
      idle(10);
      zero_counts();
      wave(8, 4, 7);
      idle(4);
      check("p8_valids",   32'(n_valid),  6);
      check("p8_lock_idx", 32'(lock_idx), 4);
      check("p8_locked",   32'(locked),   1);
      check("p8_div",      32'(div_out),  3);
      check("p8_period",   32'(period),   8);
      check("p8_errs",     32'(n_err),    0);

      // Latency: three clk edges from the first high sample to valid
      do_clr();
      idle(6);
      wave(8, 4, 1);
      @(negedge clk);
      sig_in = 1'b1;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (valid === 1'b1) begin
            lat = c;
            break;
         end
      end
      check("latency", 32'(lat), 3);
      idle(6);
      check("lat_period", 32'(period), 8);

      // Period 128 locks at 7, then period 2 relocks at 1
      do_clr();
      idle(4);
      zero_counts();
      wave(128, 64, 6);
      check("p128_locked", 32'(locked), 1);
      check("p128_div",    32'(div_out), 7);
      zero_counts();
      wave(2, 1, 8);
      idle(4);
      check("p2_errs",   32'(n_err),   1);
      check("p2_locked", 32'(locked),  1);
      check("p2_div",    32'(div_out), 1);
      check("p2_period", 32'(period),  2);

      // Locked at 4, switch to 16: one err, then relock at 4
      do_clr();
      idle(4);
      wave(4, 2, 6);
      check("p4_div", 32'(div_out), 2);
      zero_counts();
      wave(16, 8, 6);
      idle(4);
      check("p16_errs",       32'(n_err),      1);
      check("p16_err_locked", 32'(err_locked), 0);
      check("p16_err_div",    32'(err_div),    0);
      check("p16_locked",     32'(locked),     1);
      check("p16_div",        32'(div_out),    4);

      // Period 12: every valid is an error, never locks
      do_clr();
      idle(4);
      zero_counts();
      wave(12, 6, 6);
      idle(4);
      check("p12_valids", 32'(n_valid), 5);
      check("p12_errs",   32'(n_err),   5);
      check("p12_locked", 32'(locked),  0);

      // Timeout while locked, then the next edge is a HUNT edge
      do_clr();
      idle(4);
      wave(8, 4, 6);
      zero_counts();
      idle(300);
      check("to_errs",   32'(n_err),   1);
      check("to_locked", 32'(locked),  0);
      check("to_div",    32'(div_out), 0);
      wave(8, 4, 1);
      idle(4);
      check("to_no_valid", 32'(n_valid), 0);

      // Edge coinciding with timeout: measured as 257 and rejected
      do_clr();
      idle(4);
      wave(8, 4, 6);
      zero_counts();
      wave(257, 4, 1);
      wave(8, 4, 1);
      idle(4);
      check("co_valids", 32'(n_valid),     2);
      check("co_errs",   32'(n_err),       1);
      check("co_period", 32'(last_period), 257);
      check("co_locked", 32'(locked),      0);

      // Asynchronous reset mid-LOCKED, with sig_in high across release
      do_clr();
      idle(4);
      wave(8, 4, 6);
      check("ar_pre_locked", 32'(locked), 1);
      @(negedge clk);
      sig_in = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("ar_locked", 32'(locked),  0);
      check("ar_div",    32'(div_out), 0);
      check("ar_period", 32'(period),  0);
      check("ar_valid",  32'(valid),   0);
      check("ar_err",    32'(err),     0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      zero_counts();
      repeat (6) @(negedge clk);
      idle(4);
      wave(8, 4, 2);
      idle(4);
      check("ar_valids", 32'(n_valid), 1);
      check("ar_p8",     32'(period),  8);

      // clr on the cycle an edge is acted on: HUNT, no valid
      zero_counts();
      @(negedge clk);
      sig_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      idle(4);
      check("clr_no_valid", 32'(n_valid), 0);
      check("clr_period",   32'(period),  0);
      wave(8, 4, 2);
      idle(4);
      check("clr_hunt_valids", 32'(n_valid), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
